// File: rtl/quadrature_decoder_pkg.sv
// Shared definitions for the quadrature decoder: FSM encoding, Gray phase
// constants and transition classification helpers.
package qdec_pkg;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef logic [1:0] phase_t;

    localparam phase_t QP_00 = 2'b00;
    localparam phase_t QP_01 = 2'b01;
    localparam phase_t QP_11 = 2'b11;
    localparam phase_t QP_10 = 2'b10;

    typedef enum logic [1:0] {
        TR_NONE = 2'd0,
        TR_FWD  = 2'd1,
        TR_REV  = 2'd2,
        TR_ERR  = 2'd3
    } trans_t;

    // Forward Gray order is 00 -> 01 -> 11 -> 10 -> 00.
    function automatic phase_t fwd_next(input phase_t phase);
        phase_t nxt;
        case (phase)
            QP_00:   nxt = QP_01;
            QP_01:   nxt = QP_11;
            QP_11:   nxt = QP_10;
            default: nxt = QP_00;
        endcase
        return nxt;
    endfunction

    function automatic trans_t classify(input phase_t prev, input phase_t cur);
        trans_t tr;
        if (cur == prev)
            tr = TR_NONE;
        else if (cur == fwd_next(prev))
            tr = TR_FWD;
        else if (prev == fwd_next(cur))
            tr = TR_REV;
        else
            tr = TR_ERR;
        return tr;
    endfunction

endpackage

// File: rtl/quadrature_decoder_if.sv
// Encoder-side signal bundle: raw A/B pads in, step/dir/err status out.
interface quadrature_decoder_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 a_in;
    logic                 b_in;
    logic                 step;
    logic                 dir;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_count;
    logic                 locked;

    modport master (
        output a_in, b_in,
        input  step, dir, err, err_count, locked
    );

    modport slave (
        input  a_in, b_in,
        output step, dir, err, err_count, locked
    );
endinterface

// File: rtl/quadrature_decoder_sync_filter.sv
// Per-channel 2-flop synchroniser followed by a stability filter that only
// passes a new level after FILTER_LEN consecutive cycles at the synchroniser.
module qdec_sync_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic filt,
    output logic stable
);
    localparam int             CNT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             s1_p0;
    logic             s2_p1;
    logic             filt_p2;
    logic [CNT_W-1:0] cnt_p2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_p0   <= 1'b0;
            s2_p1   <= 1'b0;
            filt_p2 <= 1'b0;
            cnt_p2  <= '0;
        end else begin
            // stage p0/p1: metastability guard
            s1_p0 <= raw;
            s2_p1 <= s1_p0;
            // stage p2: filter
            if (s2_p1 == filt_p2) begin
                cnt_p2 <= '0;
            end else if (cnt_p2 == CNT_LAST) begin
                filt_p2 <= s2_p1;
                cnt_p2  <= '0;
            end else begin
                cnt_p2 <= cnt_p2 + 1'b1;
            end
        end
    end

    assign filt   = filt_p2;
    assign stable = (s2_p1 == filt_p2) && (cnt_p2 == '0);

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature decoder top: filtered A/B channels feed a lock FSM and a Gray
// transition decoder producing step/dir pulses and a saturating error count.
module quadrature_decoder
    import qdec_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int ERR_CNT_W  = 8
) (
    input logic                 clk,
    input logic                 reset,
    quadrature_decoder_if.slave bus
);
    localparam int               LOCK_W    = $clog2(FILTER_LEN + 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(FILTER_LEN - 1);

    logic filt_a, filt_b;
    logic stable_a, stable_b;

    qdec_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk    (clk),
        .reset  (reset),
        .raw    (bus.a_in),
        .filt   (filt_a),
        .stable (stable_a)
    );

    qdec_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk    (clk),
        .reset  (reset),
        .raw    (bus.b_in),
        .filt   (filt_b),
        .stable (stable_b)
    );

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [0:0]           state_p3;
    logic [LOCK_W-1:0]    lock_cnt_p3;
    phase_t               prev_p3;
    logic                 step_p3;
    logic                 dir_p3;
    logic                 err_p3;
    logic [ERR_CNT_W-1:0] err_count_p3;
    logic                 locked_p3;

    phase_t cur;
    trans_t trans;

    assign cur   = {filt_a, filt_b};
    assign trans = classify(prev_p3, cur);

    // stage p3: lock FSM, transition decode and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_p3     <= ST_INIT;
            lock_cnt_p3  <= '0;
            prev_p3      <= QP_00;
            step_p3      <= 1'b0;
            dir_p3       <= 1'b0;
            err_p3       <= 1'b0;
            err_count_p3 <= '0;
            locked_p3    <= 1'b0;
        end else begin
            step_p3 <= 1'b0;
            err_p3  <= 1'b0;
            if (state_p3 == ST_INIT) begin
                // Both channels must sit quietly for a full filter window before
                // the starting phase is trusted.
                if (stable_a && stable_b) begin
                    if (lock_cnt_p3 == LOCK_LAST) begin
                        prev_p3     <= cur;
                        locked_p3   <= 1'b1;
                        state_p3    <= ST_RUN;
                        lock_cnt_p3 <= '0;
                    end else begin
                        lock_cnt_p3 <= lock_cnt_p3 + 1'b1;
                    end
                end else begin
                    lock_cnt_p3 <= '0;
                end
            end else begin
                prev_p3 <= cur;
                case (trans)
                    TR_FWD: begin
                        step_p3 <= 1'b1;
                        dir_p3  <= 1'b1;
                    end
                    TR_REV: begin
                        step_p3 <= 1'b1;
                        dir_p3  <= 1'b0;
                    end
                    TR_ERR: begin
                        err_p3       <= 1'b1;
                        err_count_p3 <= sat_inc(err_count_p3);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.step      = step_p3;
    assign bus.dir       = dir_p3;
    assign bus.err       = err_p3;
    assign bus.err_count = err_count_p3;
    assign bus.locked    = locked_p3;

endmodule
